// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants shared by the sync generator and the display colour generator.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int H_DISP = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_DISP + H_FP + H_SYNC + H_BP;

  localparam int V_DISP = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_ACTIVE = 1'b0;

  localparam int DIV_DEFAULT   = 4;
  localparam int BLINK_W       = 6;
  localparam int BLINK_DEFAULT = 30;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_range(coord_t v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate enable: a free-running modulo-DIV counter whose terminal count is the tick.
module vga_pixel_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pixel_tick
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) div_cnt_q <= '0;
    else      div_cnt_q <= div_cnt_d;
  end

  assign pixel_tick = (div_cnt_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters, registered syncs, video_on, strobes and frame-locked blink.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int DIV          = DIV_DEFAULT,
  parameter int H_DISP       = vga_pkg::H_DISP,
  parameter int H_FP         = vga_pkg::H_FP,
  parameter int H_SYNC       = vga_pkg::H_SYNC,
  parameter int H_BP         = vga_pkg::H_BP,
  parameter int V_DISP       = vga_pkg::V_DISP,
  parameter int V_FP         = vga_pkg::V_FP,
  parameter int V_SYNC       = vga_pkg::V_SYNC,
  parameter int V_BP         = vga_pkg::V_BP,
  parameter int BLINK_FRAMES = BLINK_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pixel_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic               blink
);

  localparam int HT    = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_DISP + H_FP;
  localparam int HS_HI = H_DISP + H_FP + H_SYNC - 1;
  localparam int VS_LO = V_DISP + V_FP;
  localparam int VS_HI = V_DISP + V_FP + V_SYNC - 1;

  localparam coord_t X_LAST = COORD_W'(HT - 1);
  localparam coord_t Y_LAST = COORD_W'(VT - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic tick;

  vga_pixel_tick #(.DIV(DIV)) u_tick (
    .clk        (clk),
    .rst        (rst),
    .pixel_tick (tick)
  );

  coord_t x_q, x_d, y_q, y_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic blink_q, blink_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

  // Syncs and video_on decode the next coordinates so they land with the counters.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end

    hsync_d       = in_range(x_d, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d       = in_range(y_d, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    video_on_d    = (int'(x_d) < H_DISP) && (int'(y_d) < V_DISP);
    line_start_d  = tick && (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);

    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (frame_start_d) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Reset parks the raster on the last blanking pixel so the first tick starts a frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q           <= X_LAST;
      y_q           <= Y_LAST;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      blink_q       <= 1'b0;
      blink_cnt_q   <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      blink_q       <= blink_d;
      blink_cnt_q   <= blink_cnt_d;
    end
  end

  assign pixel_tick  = tick;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign blink       = blink_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full 640x480 instance for line-level timing, reduced-geometry instance for frames.
module tb_vga_sync_gen;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       f_tick, f_hs, f_vs, f_von, f_ls, f_fs, f_blink;
  logic [9:0] f_x, f_y;
  logic       s_tick, s_hs, s_vs, s_von, s_ls, s_fs, s_blink;
  logic [9:0] s_x, s_y;

  vga_sync_gen u_full (
    .clk(clk), .rst(rst), .pixel_tick(f_tick), .pixel_x(f_x), .pixel_y(f_y),
    .hsync(f_hs), .vsync(f_vs), .video_on(f_von), .line_start(f_ls),
    .frame_start(f_fs), .blink(f_blink)
  );

  vga_sync_gen #(
    .DIV(DIV), .H_DISP(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_DISP(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .BLINK_FRAMES(2)
  ) u_small (
    .clk(clk), .rst(rst), .pixel_tick(s_tick), .pixel_x(s_x), .pixel_y(s_y),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .line_start(s_ls),
    .frame_start(s_fs), .blink(s_blink)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int k = 0;  // clock edges since the last edge that sampled rst low

  always @(posedge clk) begin
    if (!rst) k <= 0;
    else      k <= k + 1;
  end

  logic [26:0] act_f, act_s;
  assign act_f = {f_tick, f_x, f_y, f_hs, f_vs, f_von, f_ls, f_fs, f_blink};
  assign act_s = {s_tick, s_x, s_y, s_hs, s_vs, s_von, s_ls, s_fs, s_blink};

  // Expected outputs k edges after reset release, from the raster arithmetic alone.
  function automatic logic [26:0] model(input int kk, input int hd, input int hf, input int hsw,
                                        input int hb, input int vd, input int vf, input int vsw,
                                        input int vb, input int bf);
    int ht, vt, t, p, x, y, f;
    logic tk, ed, hs, vs, von, ls, fs, bl;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    t  = kk / DIV;
    tk = (kk % DIV) == DIV - 1;
    if (t == 0) return {tk, 10'(ht - 1), 10'(vt - 1), 6'b110000};
    p   = t - 1;
    x   = p % ht;
    y   = (p / ht) % vt;
    f   = p / (ht * vt) + 1;
    ed  = (kk % DIV) == 0;
    hs  = !((x >= hd + hf) && (x < hd + hf + hsw));
    vs  = !((y >= vd + vf) && (y < vd + vf + vsw));
    von = (x < hd) && (y < vd);
    ls  = ed && (x == 0);
    fs  = ls && (y == 0);
    bl  = ((f / bf) % 2) == 1;
    return {tk, 10'(x), 10'(y), hs, vs, von, ls, fs, bl};
  endfunction

  function automatic logic [26:0] exp_full(input int kk);
    return model(kk, 640, 16, 96, 48, 480, 10, 2, 33, 30);
  endfunction

  function automatic logic [26:0] exp_small(input int kk);
    return model(kk, 16, 4, 6, 4, 8, 2, 2, 3, 2);
  endfunction

  task automatic test_reset();
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({f_x, f_y} !== {10'd799, 10'd524}) begin
      fails++; $display("FAIL reset_full_xy act=%0d,%0d exp=799,524", f_x, f_y);
    end
    tests++;
    if ({f_tick, f_hs, f_vs, f_von, f_ls, f_fs, f_blink} !== 7'b0110000) begin
      fails++; $display("FAIL reset_full_flags act=%b exp=0110000", {f_tick, f_hs, f_vs, f_von, f_ls, f_fs, f_blink});
    end
    tests++;
    if ({s_x, s_y} !== {10'd29, 10'd14}) begin
      fails++; $display("FAIL reset_small_xy act=%0d,%0d exp=29,14", s_x, s_y);
    end
    tests++;
    if ({s_tick, s_hs, s_vs, s_von, s_ls, s_fs, s_blink} !== 7'b0110000) begin
      fails++; $display("FAIL reset_small_flags act=%b exp=0110000", {s_tick, s_hs, s_vs, s_von, s_ls, s_fs, s_blink});
    end
  endtask

  task automatic test_startup();
    rst = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      tests++;
      if (f_tick !== ((c % DIV) == DIV - 1)) begin
        fails++; $display("FAIL startup_tick c=%0d act=%b exp=%b", c, f_tick, (c % DIV) == DIV - 1);
      end
      if (c == 4) begin
        tests++;
        if ({f_x, f_y, f_von, f_hs, f_vs, f_fs, f_ls} !== {10'd0, 10'd0, 5'b11111}) begin
          fails++; $display("FAIL startup_first_pixel act=%0d,%0d von=%b hs=%b vs=%b fs=%b ls=%b exp=0,0 11111",
                            f_x, f_y, f_von, f_hs, f_vs, f_fs, f_ls);
        end
        tests++;
        if ({s_x, s_y, s_fs} !== {10'd0, 10'd0, 1'b1}) begin
          fails++; $display("FAIL startup_small act=%0d,%0d fs=%b exp=0,0 fs=1", s_x, s_y, s_fs);
        end
      end
      if (c == 5) begin
        tests++;
        if ({f_fs, f_ls} !== 2'b00) begin
          fails++; $display("FAIL startup_strobe_width act=fs%b ls%b exp=00", f_fs, f_ls);
        end
      end
    end
  endtask

  task automatic test_line();
    int seen = 0, clks = 0, hsl = 0, vl = 0, first_x = -1, guard = 0;
    logic bad_f = 1'b0, bad_s = 1'b0;
    while (seen < 2 && guard < 8000) begin
      @(negedge clk); guard++;
      if (!bad_f) begin
        tests++;
        if (act_f !== exp_full(k)) begin
          fails++; bad_f = 1'b1; $display("FAIL line_model_full k=%0d act=%h exp=%h", k, act_f, exp_full(k));
        end
      end
      if (!bad_s) begin
        tests++;
        if (act_s !== exp_small(k)) begin
          fails++; bad_s = 1'b1; $display("FAIL line_model_small k=%0d act=%h exp=%h", k, act_s, exp_small(k));
        end
      end
      if (f_ls) begin
        if (seen > 0) begin
          tests++;
          if (clks != 3200) begin fails++; $display("FAIL line_period act=%0d exp=3200", clks); end
          tests++;
          if (hsl != 384) begin fails++; $display("FAIL hsync_width act=%0d exp=384", hsl); end
          tests++;
          if (first_x != 656) begin fails++; $display("FAIL hsync_start_x act=%0d exp=656", first_x); end
          tests++;
          if (vl != 640) begin fails++; $display("FAIL hblank_len act=%0d exp=640", vl); end
        end
        seen++; clks = 0; hsl = 0; vl = 0; first_x = -1;
      end
      clks++;
      if (!f_hs) begin
        if (hsl == 0) first_x = int'(f_x);
        hsl++;
      end
      if (!f_von) vl++;
    end
    tests++;
    if (seen < 2) begin fails++; $display("FAIL line_timeout act=%0d exp=2", seen); end
  endtask

  task automatic test_frame();
    int seen = 0, lines = 0, vsl = 0, guard = 0, f;
    logic bad_s = 1'b0;
    while (seen < 4 && guard < 9000) begin
      @(negedge clk); guard++;
      if (!bad_s) begin
        tests++;
        if (act_s !== exp_small(k)) begin
          fails++; bad_s = 1'b1; $display("FAIL frame_model_small k=%0d act=%h exp=%h", k, act_s, exp_small(k));
        end
      end
      if (s_fs) begin
        if (seen > 0) begin
          tests++;
          if (lines != 15) begin fails++; $display("FAIL lines_per_frame act=%0d exp=15", lines); end
          tests++;
          if (vsl != 240) begin fails++; $display("FAIL vsync_width act=%0d exp=240", vsl); end
        end
        f = (k / DIV - 1) / 450 + 1;
        tests++;
        if (s_blink !== ((f / 2) % 2 == 1)) begin
          fails++; $display("FAIL blink_frame%0d act=%b exp=%b", f, s_blink, (f / 2) % 2 == 1);
        end
        seen++; lines = 0; vsl = 0;
      end
      if (s_ls) lines++;
      if (!s_vs) vsl++;
    end
    tests++;
    if (seen < 4) begin fails++; $display("FAIL frame_timeout act=%0d exp=4", seen); end
  endtask

  task automatic test_wrap_corner();
    int guard = 0;
    while (!(s_tick && s_x == 10'd29 && s_y == 10'd7) && guard < 2000) begin
      @(negedge clk); guard++;
    end
    @(negedge clk);
    tests++;
    if ({s_x, s_y, s_von, s_ls} !== {10'd0, 10'd8, 1'b0, 1'b1}) begin
      fails++; $display("FAIL wrap_vblank act=%0d,%0d von=%b ls=%b exp=0,8 von=0 ls=1", s_x, s_y, s_von, s_ls);
    end
    guard = 0;
    while (!(s_tick && s_x == 10'd29 && s_y == 10'd14) && guard < 2000) begin
      @(negedge clk); guard++;
    end
    @(negedge clk);
    tests++;
    if ({s_x, s_y, s_von, s_fs} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL wrap_frame act=%0d,%0d von=%b fs=%b exp=0,0 von=1 fs=1", s_x, s_y, s_von, s_fs);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    logic bad = 1'b0;
    while (!(s_x == 10'd10 && s_y == 10'd5) && guard < 2000) begin
      @(negedge clk); guard++;
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tests++;
    if ({s_x, s_y, s_hs, s_vs, s_von, s_blink} !== {10'd29, 10'd14, 4'b1100}) begin
      fails++; $display("FAIL midreset_small act=%0d,%0d hs%b vs%b von%b bl%b exp=29,14 1100",
                        s_x, s_y, s_hs, s_vs, s_von, s_blink);
    end
    tests++;
    if ({f_x, f_y, f_hs, f_vs, f_von, f_blink} !== {10'd799, 10'd524, 4'b1100}) begin
      fails++; $display("FAIL midreset_full act=%0d,%0d exp=799,524", f_x, f_y);
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (!bad) begin
        tests++;
        if (act_s !== exp_small(k) || act_f !== exp_full(k)) begin
          fails++; bad = 1'b1;
          $display("FAIL midreset_restart c=%0d act=%h/%h exp=%h/%h", c, act_s, act_f, exp_small(k), exp_full(k));
        end
      end
    end
  endtask

  task automatic test_random_reset();
    logic bad_f = 1'b0, bad_s = 1'b0;
    int n, r;
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(4000, 50);
      r = $urandom_range(3, 1);
      for (int c = 0; c < n + r; c++) begin
        rst = (c < n);
        @(negedge clk);
        if (!bad_f) begin
          tests++;
          if (act_f !== exp_full(k)) begin
            fails++; bad_f = 1'b1; $display("FAIL random_full it=%0d k=%0d act=%h exp=%h", it, k, act_f, exp_full(k));
          end
        end
        if (!bad_s) begin
          tests++;
          if (act_s !== exp_small(k)) begin
            fails++; bad_s = 1'b1; $display("FAIL random_small it=%0d k=%0d act=%h exp=%h", it, k, act_s, exp_small(k));
          end
        end
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_line();
    test_frame();
    test_wrap_corner();
    test_reset_mid();
    test_random_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
